controller_router: RTL

- Parametrised, registered successor to the combinational controller select mux.
- Routes one of NUM_SRC active-low button buses to one of NUM_DST console ports: breadboard, N64 and remote sources; NES1, NES0, SNES1 and SNES0 ports.
- Adds a select stability filter, a glitch-free blanking interval on every route change, and status outputs.
- Sits between the source decoders and the console shift-register drivers.

---
 rtl/controller_router_pkg.sv | 29 ++
 rtl/controller_router_select_stabilizer.sv | 42 ++++
 rtl/controller_router.sv | 134 +++++++++++++
 3 files changed

// File: rtl/controller_router_pkg.sv
// controller_router_pkg: shared state type, OFF constant and select-field helpers.
// rev 1.0
`default_nettype none

package controller_router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } router_state_t;

  // Button buses are active-low, so a released (OFF) bit is a one.
  localparam logic BTN_OFF_BIT = 1'b1;

  function automatic logic [31:0] sel_field(input logic [31:0] sel,
                                            input int unsigned lsb,
                                            input int unsigned w);
    return (sel >> lsb) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic route_ok(input logic [31:0] src, input logic [31:0] dst,
                                    input logic [31:0] nsrc, input logic [31:0] ndst);
    return (src < nsrc) && (dst < ndst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/controller_router_select_stabilizer.sv
// select_stabilizer: holds a candidate select and pulses commit once it has been stable long enough.
// rev 1.0
`default_nettype none

module select_stabilizer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W        = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] select_in,
  input  logic [WIDTH-1:0] committed_in,
  output logic [WIDTH-1:0] cand_out,
  output logic             commit_out
);

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      cand_q  <= '0;
      count_q <= '0;
    end else begin
      cand_q <= select_in;
      if (select_in != cand_q)
        count_q <= '0;
      else if (count_q != COUNT_MAX)
        count_q <= count_q + CNT_W'(1);
    end
  end

  // Fires once: the committed select catches up with the candidate on the next edge.
  assign commit_out = (count_q == COUNT_MAX) && (cand_q != committed_in);
  assign cand_out   = cand_q;

endmodule

`default_nettype wire

// File: rtl/controller_router.sv
// controller_router: filtered, blanked router of active-low button buses to console ports.
// rev 1.0 -- define CONTROLLER_ROUTER_SYNC_EN to add a 2-flop synchroniser on src_in.
`default_nettype none

module controller_router
  import controller_router_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int NUM_DST       = 4,
  parameter int BTN_W         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 2,
  localparam int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int DST_W        = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_SRC*BTN_W-1:0] src_in,
  input  logic [SRC_W+DST_W-1:0]   select_in,
  output logic [NUM_DST*BTN_W-1:0] dst_out,
  output logic                     route_valid_out,
  output logic [SRC_W-1:0]         active_src_out,
  output logic [DST_W-1:0]         active_dst_out,
  output logic                     switching_out
);

  localparam int SEL_W = SRC_W + DST_W;
  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BTN_W-1:0] OFF        = {BTN_W{BTN_OFF_BIT}};
  localparam logic [BLK_W-1:0] BLANK_INIT = BLK_W'(BLANK_CYCLES - 1);

  router_state_t      state_q, state_d;
  logic [BLK_W-1:0]   blank_q, blank_d;
  logic [SEL_W-1:0]   cand;
  logic               commit;
  logic               target_ok;
  logic [NUM_SRC*BTN_W-1:0] src_s;
  logic [BTN_W-1:0]   route_data;

  select_stabilizer #(
    .WIDTH         (SEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stab (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .select_in    (select_in),
    .committed_in ({active_src_out, active_dst_out}),
    .cand_out     (cand),
    .commit_out   (commit)
  );

`ifdef CONTROLLER_ROUTER_SYNC_EN
  logic [NUM_SRC*BTN_W-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      sync1_q <= {NUM_SRC{OFF}};
      sync2_q <= {NUM_SRC{OFF}};
    end else begin
      sync1_q <= src_in;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_in;
`endif

  assign target_ok = route_ok(32'(active_src_out), 32'(active_dst_out),
                              32'(NUM_SRC), 32'(NUM_DST));

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q        <= IDLE;
      blank_q        <= '0;
      active_src_out <= '0;
      active_dst_out <= '0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      if (commit) begin
        active_src_out <= SRC_W'(sel_field(32'(cand), DST_W, SRC_W));
        active_dst_out <= DST_W'(sel_field(32'(cand), 0, DST_W));
      end
    end
  end

  // A commit always wins, so a new request during blanking restarts the full interval.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    if (commit) begin
      state_d = BLANK;
      blank_d = BLANK_INIT;
    end else begin
      case (state_q)
        BLANK: begin
          if (blank_q == '0)
            state_d = target_ok ? ACTIVE : IDLE;
          else
            blank_d = blank_q - BLK_W'(1);
        end
        IDLE, ACTIVE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    route_data = OFF;
    for (int s = 0; s < NUM_SRC; s++)
      if (SRC_W'(s) == active_src_out)
        route_data = src_s[s*BTN_W +: BTN_W];
  end

  // Outputs are registered from the next state so OFF lands right after the commit edge.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      dst_out         <= {NUM_DST{OFF}};
      route_valid_out <= 1'b0;
      switching_out   <= 1'b0;
    end else begin
      route_valid_out <= (state_d == ACTIVE);
      switching_out   <= (state_d == BLANK);
      for (int d = 0; d < NUM_DST; d++)
        dst_out[d*BTN_W +: BTN_W] <= ((state_d == ACTIVE) && (DST_W'(d) == active_dst_out))
                                     ? route_data : OFF;
    end
  end

endmodule

`default_nettype wire
